// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite command initiator.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_master_if.sv
// Command/response port and AXI4-Lite channels of the initiator, bundled with directional views.
interface axi_lite_master_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int LAT_WIDTH      = 16
);
    logic                          CMD_VALID;
    logic                          CMD_READY;
    logic                          CMD_WRITE;
    logic [AXI_ADDR_WIDTH-1:0]     CMD_ADDR;
    logic [AXI_DATA_WIDTH-1:0]     CMD_WDATA;
    logic [AXI_DATA_WIDTH/8-1:0]   CMD_WSTRB;
    logic                          RSP_VALID;
    logic                          RSP_READY;
    logic [AXI_DATA_WIDTH-1:0]     RSP_RDATA;
    logic [1:0]                    RSP_RESP;
    logic [LAT_WIDTH-1:0]          RSP_CYCLES;
    logic [AXI_ADDR_WIDTH-1:0]     AWADDR;
    logic [2:0]                    AWPROT;
    logic                          AWVALID;
    logic                          AWREADY;
    logic [AXI_DATA_WIDTH-1:0]     WDATA;
    logic [AXI_DATA_WIDTH/8-1:0]   WSTRB;
    logic                          WVALID;
    logic                          WREADY;
    logic [1:0]                    BRESP;
    logic                          BVALID;
    logic                          BREADY;
    logic [AXI_ADDR_WIDTH-1:0]     ARADDR;
    logic [2:0]                    ARPROT;
    logic                          ARVALID;
    logic                          ARREADY;
    logic [AXI_DATA_WIDTH-1:0]     RDATA;
    logic [1:0]                    RRESP;
    logic                          RVALID;
    logic                          RREADY;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_WSTRB, RSP_READY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
        output CMD_READY, RSP_VALID, RSP_RDATA, RSP_RESP, RSP_CYCLES,
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARADDR, ARPROT, ARVALID, RREADY
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_WSTRB, RSP_READY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
        input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_RESP, RSP_CYCLES,
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARADDR, ARPROT, ARVALID, RREADY
    );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction, one response out.
// state   | meaning
// IDLE    | CMD_READY high, waiting for a command
// WR_REQ  | AW and/or W still awaiting handshake
// WR_RESP | BREADY high, waiting for BVALID
// RD_REQ  | ARVALID high, waiting for ARREADY
// RD_RESP | RREADY high, waiting for RVALID
// RSP     | RSP_VALID high, waiting for RSP_READY
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int LAT_WIDTH      = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    axi_lite_master_if.master    bus
);

    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

    state_t                      r_state;
    logic                        r_cmd_ready;
    logic [AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [AXI_DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_WIDTH-1:0]       r_wstrb;
    logic                        r_awvalid;
    logic                        r_wvalid;
    logic                        r_bready;
    logic                        r_arvalid;
    logic                        r_rready;
    logic                        r_rsp_valid;
    logic [AXI_DATA_WIDTH-1:0]   r_rsp_rdata;
    resp_t                       r_rsp_resp;
    logic [LAT_WIDTH-1:0]        r_cycles;

    logic [LAT_WIDTH-1:0]        w_cycles_inc;
    logic                        w_aw_done;
    logic                        w_w_done;

    assign w_cycles_inc = (&r_cycles) ? r_cycles : r_cycles + 1'b1;
    // A channel counts as done if it already dropped VALID or handshakes this cycle.
    assign w_aw_done    = !r_awvalid || bus.AWREADY;
    assign w_w_done     = !r_wvalid  || bus.WREADY;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= OKAY;
            r_cycles    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.CMD_VALID) begin
                        r_cmd_ready <= 1'b0;
                        r_cycles    <= '0;
                        r_addr      <= bus.CMD_ADDR;
                        if (bus.CMD_WRITE) begin
                            r_wdata   <= bus.CMD_WDATA;
                            r_wstrb   <= bus.CMD_WSTRB;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WR_REQ;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    r_cycles <= w_cycles_inc;
                    if (r_awvalid && bus.AWREADY) r_awvalid <= 1'b0;
                    if (r_wvalid && bus.WREADY)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    r_cycles <= w_cycles_inc;
                    if (bus.BVALID) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= resp_t'(bus.BRESP);
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RSP;
                    end
                end
                RD_REQ: begin
                    r_cycles <= w_cycles_inc;
                    if (bus.ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    r_cycles <= w_cycles_inc;
                    if (bus.RVALID) begin
                        r_rready    <= 1'b0;
                        r_rsp_resp  <= resp_t'(bus.RRESP);
                        r_rsp_rdata <= bus.RDATA;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RSP;
                    end
                end
                RSP: begin
                    if (bus.RSP_READY) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.CMD_READY  = r_cmd_ready;
    assign bus.RSP_VALID  = r_rsp_valid;
    assign bus.RSP_RDATA  = r_rsp_rdata;
    assign bus.RSP_RESP   = r_rsp_resp;
    assign bus.RSP_CYCLES = r_cycles;
    assign bus.AWADDR     = r_addr;
    assign bus.AWPROT     = AXI_PROT_DEFAULT;
    assign bus.AWVALID    = r_awvalid;
    assign bus.WDATA      = r_wdata;
    assign bus.WSTRB      = r_wstrb;
    assign bus.WVALID     = r_wvalid;
    assign bus.BREADY     = r_bready;
    assign bus.ARADDR     = r_addr;
    assign bus.ARPROT     = AXI_PROT_DEFAULT;
    assign bus.ARVALID    = r_arvalid;
    assign bus.RREADY     = r_rready;

endmodule

// File: tb/tb_axi_lite_master.sv
// Scenario bench for axi_lite_master with a wait-state-configurable slave and a response scoreboard.
module tb_axi_lite_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 16;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
        logic [LW-1:0] cycles;
    } exp_t;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;

    axi_lite_master_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .LAT_WIDTH(LW)) bus ();

    axi_lite_master #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .LAT_WIDTH(LW)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus)
    );

    always #5 ACLK = ~ACLK;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0]    bresp_cfg = 2'b00;
    logic [1:0]    rresp_cfg = 2'b00;
    logic [DW-1:0] rdata_cfg = '0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

    // Slave model: each READY/VALID rises after a programmable number of wait cycles.
    always @(posedge ACLK) begin
        cyc    <= cyc + 1;
        aw_cnt <= (bus.AWVALID && !bus.AWREADY) ? aw_cnt + 1 : 0;
        w_cnt  <= (bus.WVALID  && !bus.WREADY)  ? w_cnt  + 1 : 0;
        ar_cnt <= (bus.ARVALID && !bus.ARREADY) ? ar_cnt + 1 : 0;
        b_cnt  <= (bus.BREADY  && !bus.BVALID)  ? b_cnt  + 1 : 0;
        r_cnt  <= (bus.RREADY  && !bus.RVALID)  ? r_cnt  + 1 : 0;
    end

    assign bus.AWREADY = bus.AWVALID && (aw_cnt >= aw_wait);
    assign bus.WREADY  = bus.WVALID  && (w_cnt  >= w_wait);
    assign bus.ARREADY = bus.ARVALID && (ar_cnt >= ar_wait);
    assign bus.BVALID  = bus.BREADY  && (b_cnt  >= b_wait);
    assign bus.RVALID  = bus.RREADY  && (r_cnt  >= r_wait);
    assign bus.BRESP   = bresp_cfg;
    assign bus.RRESP   = rresp_cfg;
    assign bus.RDATA   = rdata_cfg;

    // Scoreboard consumer: every response handshake pops one expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (ARESETN && bus.RSP_VALID && bus.RSP_READY) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_rsp: got rdata=%h resp=%0d cycles=%0d, expected no response",
                             bus.RSP_RDATA, bus.RSP_RESP, bus.RSP_CYCLES);
                end else begin
                    e = sb.pop_front();
                    if ({bus.RSP_RDATA, bus.RSP_RESP, bus.RSP_CYCLES} !== e) begin
                        n_fail++;
                        $display("FAIL sb_rsp: got rdata=%h resp=%0d cycles=%0d, expected rdata=%h resp=%0d cycles=%0d",
                                 bus.RSP_RDATA, bus.RSP_RESP, bus.RSP_CYCLES, e.rdata, e.resp, e.cycles);
                    end
                end
            end
        end
    end

    function automatic exp_t mk(input logic [DW-1:0] d, input logic [1:0] r, input int c);
        exp_t e;
        e.rdata  = d;
        e.resp   = r;
        e.cycles = LW'(c);
        return e;
    endfunction

    // Expected latency: request phase (longest channel stall + 1) plus response phase (wait + 1).
    function automatic int wr_lat(input int aw_w, input int w_w, input int b_w);
        return ((aw_w > w_w) ? aw_w : w_w) + 1 + b_w + 1;
    endfunction

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW/8-1:0] s);
        bit got;
        got = 1'b0;
        bus.CMD_WRITE = wr;
        bus.CMD_ADDR  = a;
        bus.CMD_WDATA = d;
        bus.CMD_WSTRB = s;
        bus.CMD_VALID = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge ACLK);
            got = bus.CMD_READY;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL cmd_accept_timeout: CMD_READY got 0, expected 1 within 50 cycles");
        end
        @(posedge ACLK);
        #1;
        bus.CMD_VALID = 1'b0;
    endtask

    task automatic wait_rsp();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge ACLK);
            got = bus.RSP_VALID;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL rsp_timeout: RSP_VALID got 0, expected 1 within 200 cycles");
        end
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if (bus.CMD_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cmd_ready: got %b expected 1", bus.CMD_READY);
        end
        n_tests++;
        if ({bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY, bus.RSP_VALID} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_valids: got %b expected 000000",
                     {bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY, bus.RSP_VALID});
        end
        n_tests++;
        if ({bus.AWADDR, bus.WDATA, bus.WSTRB, bus.RSP_RDATA, bus.RSP_RESP, bus.RSP_CYCLES} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got awaddr=%h wdata=%h rdata=%h cycles=%0d expected all 0",
                     bus.AWADDR, bus.WDATA, bus.RSP_RDATA, bus.RSP_CYCLES);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        n_tests++;
        if (bus.CMD_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_cmd_ready: got %b expected 1", bus.CMD_READY);
        end
    endtask

    task automatic test_write_zero_wait();
        sb.push_back(mk('0, 2'b00, wr_lat(0, 0, 0)));
        send_cmd(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
        n_tests++;
        if ({bus.AWVALID, bus.WVALID, bus.AWADDR, bus.WDATA, bus.WSTRB, bus.AWPROT} !==
            {1'b1, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 3'b000}) begin
            n_fail++;
            $display("FAIL wr_cycle1_aw_w: got awv=%b wv=%b addr=%h data=%h strb=%h prot=%0d expected 1 1 00000004 deadbeef f 0",
                     bus.AWVALID, bus.WVALID, bus.AWADDR, bus.WDATA, bus.WSTRB, bus.AWPROT);
        end
        @(posedge ACLK);
        #1;
        n_tests++;
        if ({bus.BREADY, bus.AWVALID, bus.WVALID, bus.RSP_VALID} !== 4'b1000) begin
            n_fail++;
            $display("FAIL wr_cycle2_bready: got bready/awv/wv/rspv=%b expected 1000",
                     {bus.BREADY, bus.AWVALID, bus.WVALID, bus.RSP_VALID});
        end
        @(posedge ACLK);
        #1;
        n_tests++;
        if ({bus.RSP_VALID, bus.BREADY, bus.RSP_RESP, bus.RSP_CYCLES} !== {1'b1, 1'b0, 2'b00, 16'd2}) begin
            n_fail++;
            $display("FAIL wr_cycle3_rsp: got rspv=%b bready=%b resp=%0d cycles=%0d expected 1 0 0 2",
                     bus.RSP_VALID, bus.BREADY, bus.RSP_RESP, bus.RSP_CYCLES);
        end
        @(posedge ACLK);
        #1;
        n_tests++;
        if ({bus.CMD_READY, bus.RSP_VALID} !== 2'b10) begin
            n_fail++;
            $display("FAIL wr_cycle4_idle: got cmd_ready/rspv=%b expected 10", {bus.CMD_READY, bus.RSP_VALID});
        end
    endtask

    task automatic test_aw_stall();
        int aw_hi, w_hi, windows;
        bit prev_bready, addr_bad;
        aw_hi = 0; w_hi = 0; windows = 0; prev_bready = 1'b0; addr_bad = 1'b0;
        aw_wait = 3;
        sb.push_back(mk('0, 2'b00, wr_lat(3, 0, 0)));
        send_cmd(1'b1, 32'h0000_0100, 32'h1111_2222, 4'h5);
        for (int k = 0; k < 20 && !bus.RSP_VALID; k++) begin
            if (bus.AWVALID) begin
                aw_hi++;
                if (bus.AWADDR !== 32'h0000_0100) addr_bad = 1'b1;
            end
            if (bus.WVALID) w_hi++;
            if (bus.BREADY && !prev_bready) windows++;
            prev_bready = bus.BREADY;
            @(posedge ACLK);
            #1;
        end
        n_tests++;
        if (aw_hi !== 4 || addr_bad) begin
            n_fail++;
            $display("FAIL stall_awvalid: got %0d cycles (addr_bad=%b) expected 4 cycles stable", aw_hi, addr_bad);
        end
        n_tests++;
        if (w_hi !== 1) begin
            n_fail++;
            $display("FAIL stall_wvalid: got %0d cycles expected 1", w_hi);
        end
        n_tests++;
        if (windows !== 1) begin
            n_fail++;
            $display("FAIL stall_bready_windows: got %0d expected 1", windows);
        end
        n_tests++;
        if (bus.RSP_CYCLES !== 16'd5) begin
            n_fail++;
            $display("FAIL stall_rsp_cycles: got %0d expected 5", bus.RSP_CYCLES);
        end
        aw_wait = 0;
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_read_wait();
        int ar_hi, rr_hi;
        bit rr_bad;
        ar_hi = 0; rr_hi = 0; rr_bad = 1'b0;
        r_wait    = 2;
        rdata_cfg = 32'h0000_0007;
        sb.push_back(mk(32'h0000_0007, 2'b00, 1 + r_wait + 1));
        send_cmd(1'b0, 32'h0000_2000, 32'hFFFF_FFFF, 4'h0);
        for (int k = 0; k < 20 && !bus.RSP_VALID; k++) begin
            if (bus.ARVALID) begin
                ar_hi++;
                if (bus.ARADDR !== 32'h0000_2000 || bus.ARPROT !== 3'b000) rr_bad = 1'b1;
            end
            if (bus.RREADY) rr_hi++;
            if (bus.RREADY && (bus.ARVALID || bus.AWVALID || bus.BREADY)) rr_bad = 1'b1;
            @(posedge ACLK);
            #1;
        end
        n_tests++;
        if (ar_hi !== 1 || rr_hi !== 3 || rr_bad) begin
            n_fail++;
            $display("FAIL rd_channel: got arvalid=%0d rready=%0d cycles bad=%b expected 1 3 0", ar_hi, rr_hi, rr_bad);
        end
        n_tests++;
        if ({bus.RREADY, bus.RSP_RDATA, bus.RSP_RESP} !== {1'b0, 32'h0000_0007, 2'b00}) begin
            n_fail++;
            $display("FAIL rd_rsp: got rready=%b rdata=%h resp=%0d expected 0 00000007 0",
                     bus.RREADY, bus.RSP_RDATA, bus.RSP_RESP);
        end
        r_wait = 0;
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_write_decerr();
        bresp_cfg = 2'b11;
        b_wait    = 1;
        sb.push_back(mk('0, 2'b11, wr_lat(0, 0, 1)));
        send_cmd(1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hC);
        wait_rsp();
        n_tests++;
        if ({bus.RSP_RESP, bus.RSP_RDATA} !== {2'b11, 32'h0}) begin
            n_fail++;
            $display("FAIL decerr_rsp: got resp=%0d rdata=%h expected 3 00000000", bus.RSP_RESP, bus.RSP_RDATA);
        end
        @(posedge ACLK);
        #1;
        n_tests++;
        if ({bus.CMD_READY, bus.RSP_VALID} !== 2'b10) begin
            n_fail++;
            $display("FAIL decerr_idle: got cmd_ready/rspv=%b expected 10", {bus.CMD_READY, bus.RSP_VALID});
        end
        bresp_cfg = 2'b00;
        b_wait    = 0;
    endtask

    task automatic test_rsp_backpressure();
        int bad;
        bad = 0;
        bus.RSP_READY = 1'b0;
        rdata_cfg = 32'h0000_0055;
        rresp_cfg = 2'b10;
        sb.push_back(mk(32'h0000_0055, 2'b10, 2));
        send_cmd(1'b0, 32'h0000_0030, '0, 4'h0);
        wait_rsp();
        @(posedge ACLK);
        #1;
        bus.CMD_WRITE = 1'b1;
        bus.CMD_ADDR  = 32'h0000_0040;
        bus.CMD_WDATA = 32'h0000_1234;
        bus.CMD_WSTRB = 4'h3;
        bus.CMD_VALID = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge ACLK);
            if ({bus.CMD_READY, bus.RSP_VALID, bus.RSP_RDATA, bus.RSP_RESP, bus.RSP_CYCLES} !==
                {1'b0, 1'b1, 32'h0000_0055, 2'b10, 16'd2}) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d cycles with changed RSP_*/CMD_READY, expected 0", bad);
        end
        rresp_cfg = 2'b00;
        @(posedge ACLK);
        #1;
        bus.RSP_READY = 1'b1;
        sb.push_back(mk('0, 2'b00, 2));
        @(posedge ACLK);
        #1;
        n_tests++;
        if ({bus.CMD_READY, bus.RSP_VALID, bus.AWVALID} !== 3'b100) begin
            n_fail++;
            $display("FAIL bp_release: got cmd_ready/rspv/awv=%b expected 100",
                     {bus.CMD_READY, bus.RSP_VALID, bus.AWVALID});
        end
        @(posedge ACLK);
        #1;
        bus.CMD_VALID = 1'b0;
        n_tests++;
        if ({bus.CMD_READY, bus.AWVALID, bus.AWADDR, bus.WSTRB} !== {1'b0, 1'b1, 32'h0000_0040, 4'h3}) begin
            n_fail++;
            $display("FAIL bp_accept: got cmd_ready=%b awv=%b addr=%h strb=%h expected 0 1 00000040 3",
                     bus.CMD_READY, bus.AWVALID, bus.AWADDR, bus.WSTRB);
        end
        wait_rsp();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset_mid();
        bit got;
        int bad;
        got = 1'b0;
        bad = 0;
        b_wait = 1000;
        sb.push_back(mk('0, 2'b00, 0));
        send_cmd(1'b1, 32'h0000_0080, 32'h0BAD_F00D, 4'hF);
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge ACLK);
            got = bus.BREADY;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL rst_reach_wr_resp: BREADY got 0 expected 1 within 20 cycles");
        end
        @(posedge ACLK);
        #2;
        ARESETN = 1'b0;
        #1;
        sb.delete();
        n_tests++;
        if ({bus.BREADY, bus.AWVALID, bus.WVALID, bus.RSP_VALID, bus.CMD_READY} !== 5'b00001) begin
            n_fail++;
            $display("FAIL rst_async: got bready/awv/wv/rspv/cmd_ready=%b expected 00001",
                     {bus.BREADY, bus.AWVALID, bus.WVALID, bus.RSP_VALID, bus.CMD_READY});
        end
        b_wait = 0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge ACLK);
            #1;
            if (bus.RSP_VALID !== 1'b0 || bus.CMD_READY !== 1'b1) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rst_release: got %0d cycles with RSP_VALID or !CMD_READY, expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int acc[4];
        logic          wr[4];
        logic [AW-1:0] ad[4];
        bit got;
        wr = '{1'b1, 1'b0, 1'b1, 1'b0};
        ad = '{32'h0000_0200, 32'h0000_0204, 32'h0000_0208, 32'h0000_020C};
        rdata_cfg = 32'hCAFE_0001;
        bus.RSP_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got = 1'b0;
            bus.CMD_WRITE = wr[i];
            bus.CMD_ADDR  = ad[i];
            bus.CMD_WDATA = 32'h5000_0000 + DW'(i);
            bus.CMD_WSTRB = 4'hF;
            bus.CMD_VALID = 1'b1;
            sb.push_back(mk(wr[i] ? 32'h0 : 32'hCAFE_0001, 2'b00, 2));
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge ACLK);
                got = bus.CMD_READY;
            end
            @(posedge ACLK);
            acc[i] = got ? cyc : -100;
            #1;
        end
        bus.CMD_VALID = 1'b0;
        for (int i = 1; i < 4; i++) begin
            n_tests++;
            if (acc[i] - acc[i-1] !== 4) begin
                n_fail++;
                $display("FAIL b2b_spacing_%0d: got %0d cycles expected 4", i, acc[i] - acc[i-1]);
            end
        end
        wait_rsp();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        bus.CMD_VALID = 1'b0;
        bus.CMD_WRITE = 1'b0;
        bus.CMD_ADDR  = '0;
        bus.CMD_WDATA = '0;
        bus.CMD_WSTRB = '0;
        bus.RSP_READY = 1'b1;

        test_reset();
        test_write_zero_wait();
        test_aw_stall();
        test_read_wait();
        test_write_decerr();
        test_rsp_backpressure();
        test_reset_mid();
        test_back_to_back();

        repeat (3) @(posedge ACLK);
        n_tests++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_drained: got %0d pending responses expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

AXI4-Lite initiator that turns single-word commands into complete AXI4-Lite write or read transactions. It drives the coprocessor slave interface from the testbench and from host-side glue logic. Exactly one transaction is outstanding at a time. Each transaction returns one response carrying read data, the AXI response code and a cycle count.

## Interface
- AXI_DATA_WIDTH, 32: data bus width; WSTRB width is AXI_DATA_WIDTH/8.
- AXI_ADDR_WIDTH, 32: address bus width.
- LAT_WIDTH, 16: width of the saturating latency counter.

Ports:
- ACLK  in  1  clock; all logic on its rising edge.
- ARESETN  in  1  reset; asynchronous assert, active-low.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  command accepted when CMD_VALID && CMD_READY.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  AXI_ADDR_WIDTH  byte address.
- CMD_WDATA  in  AXI_DATA_WIDTH  write data.
- CMD_WSTRB  in  AXI_DATA_WIDTH/8  write byte strobes.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  response consumed when RSP_VALID && RSP_READY.
- RSP_RDATA  out  AXI_DATA_WIDTH  read data; 0 after a write.
- RSP_RESP  out  2  captured BRESP or RRESP.
- RSP_CYCLES  out  LAT_WIDTH  cycles from command accept to B/R handshake, saturating.
- AWADDR, AWPROT, AWVALID  out  ADDR, 3, 1  write address channel.
- AWREADY  in  1.
- WDATA, WSTRB, WVALID  out  DATA, DATA/8, 1  write data channel.
- WREADY  in  1.
- BRESP, BVALID  in  2, 1  write response channel.
- BREADY  out  1.
- ARADDR, ARPROT, ARVALID  out  ADDR, 3, 1  read address channel.
- ARREADY  in  1.
- RDATA, RRESP, RVALID  in  DATA, 2, 1  read data channel.
- RREADY  out  1.

## Operation
- States:
  - IDLE: CMD_READY = 1.
  - WR_REQ: AWVALID and/or WVALID high.
  - WR_RESP: BREADY = 1.
  - RD_REQ: ARVALID = 1.
  - RD_RESP: RREADY = 1.
  - RSP: RSP_VALID = 1.
- Transitions:
  - IDLE → WR_REQ on an accepted write; IDLE → RD_REQ on an accepted read. Address, data and strobe are registered on accept.
  - WR_REQ: AWVALID and WVALID rise together. Each drops independently in the cycle after its own handshake. Move to WR_RESP once both handshakes are done, including the case where both complete in the same cycle.
  - WR_RESP → RSP on BVALID. Capture BRESP; RSP_RDATA = 0.
  - RD_REQ → RD_RESP on ARREADY.
  - RD_RESP → RSP on RVALID. Capture RDATA and RRESP.
  - RSP → IDLE on RSP_READY.
- AXI rules:
  - A VALID never drops before its handshake completes.
  - Output address, data and strobes stay stable while their VALID is high.
  - Neither BREADY nor RREADY is asserted outside its response state.
- AWPROT = ARPROT = 3'b000 always.
- RSP_CYCLES:
  - Cleared on accept, incremented every cycle until the B/R handshake, saturating at all-ones.
  - Held stable while RSP_VALID is high.
- Commands offered outside IDLE are ignored (CMD_READY = 0). No buffering.
- Error responses (SLVERR, DECERR) are passed through unchanged in RSP_RESP. No retry.
- Reset mid-transaction: all VALID/READY outputs go to 0 immediately, state returns to IDLE, the in-flight transaction is dropped and no response is produced.

## Timing
- Reset values: all VALID/READY outputs 0 except CMD_READY = 1 (IDLE). All data, address, RSP_* and counter outputs 0.
- All outputs are registered; no combinational path from input to output.
- Best-case write with a zero-wait slave:
  - Accept at cycle 0.
  - AW/W handshake at cycle 1.
  - BREADY at cycle 2, B handshake at cycle 2.
  - RSP_VALID at cycle 3, RSP_CYCLES = 2.
- Best-case read: ARVALID at cycle 1, RREADY at cycle 2, RSP_VALID at cycle 3.
- Back-to-back throughput: 4 cycles per transaction with RSP_READY tied high. CMD_READY returns in the cycle after the RSP handshake.

## Structure
- Package axi_lite_pkg holds:
  - resp_t enum: OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11.
  - state enum for the six states.
  - AXI_PROT_DEFAULT = 3'b000.
- Single module; no sub-module required. The latency counter is inline.

## Test plan
- Write 0x0000_0004 ← 0xDEAD_BEEF, WSTRB 4'hF, zero-wait slave → AW and W seen at cycle 1, BREADY at cycle 2; RSP_VALID at cycle 3 with RSP_RESP = 2'b00, RSP_CYCLES = 2.
- Slave holds AWREADY low 3 cycles but WREADY immediately → WVALID drops after 1 cycle, AWVALID held 4 cycles with a stable address; single BREADY window; RSP_CYCLES = 5.
- Read 0x0000_2000, slave returns RDATA = 0x0000_0007 after 2 wait cycles → RSP_RDATA = 0x0000_0007, RSP_RESP = 2'b00, RREADY high only in RD_RESP.
- Slave answers a write with BRESP = 2'b11 → RSP_RESP = 2'b11, RSP_RDATA = 0, FSM returns to IDLE after RSP_READY.
- RSP_READY held low 10 cycles, new CMD_VALID asserted meanwhile → CMD_READY stays 0, RSP_* stable, command accepted 1 cycle after the RSP handshake.
- ARESETN pulsed low while in WR_RESP → BREADY, AWVALID and WVALID go to 0 asynchronously, no RSP_VALID; after release CMD_READY = 1.
